// File: rtl/psram_pkg.sv
// Shared opcode constants and FSM state encoding for the QSPI PSRAM responder.
package psram_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_FREAD  = 8'h0B;
  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [7:0] CMD_ENQPI  = 8'h35;
  localparam logic [7:0] CMD_EXQPI  = 8'hF5;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE} state_e;

endpackage

// File: rtl/psram_qspi_responder_if.sv
// PSRAM serial link plus the byte-wide SRAM port behind the responder.
interface psram_qspi_responder_if #(parameter int AW = 23);
  logic          sck;
  logic          ce_n;
  logic [3:0]    sio_i;
  logic [3:0]    sio_o;
  logic [3:0]    sio_oe;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [7:0]    mem_rdata;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic          qpi_mode;

  modport slave (
    input  sck, ce_n, sio_i, mem_rdata,
    output sio_o, sio_oe, mem_addr, mem_re, mem_we, mem_wdata, qpi_mode
  );

  modport master (
    output sck, ce_n, sio_i, mem_rdata,
    input  sio_o, sio_oe, mem_addr, mem_re, mem_we, mem_wdata, qpi_mode
  );
endinterface

// File: rtl/psram_sck_edge.sv
// Samples sck in the clk domain and emits rise/fall events, suppressed while deselected.
module psram_sck_edge (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ce_n,
  output logic rise,
  output logic fall
);
  logic sck_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) sck_q <= 1'b0;
    else     sck_q <= sck;

  assign rise = sck & ~sck_q & ~ce_n;
  assign fall = ~sck & sck_q & ~ce_n;
endmodule

// File: rtl/psram_qspi_responder.sv
// PSRAM device end of the SPI/QSPI/QPI link: decodes cmd/addr/wait/data phases
// into byte accesses on a synchronous SRAM port.
module psram_qspi_responder
  import psram_pkg::*;
#(
  parameter int AW        = 23,
  parameter int WAIT_FAST = 8,
  parameter int WAIT_QUAD = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  psram_qspi_responder_if.slave bus
);
  state_e        state, state_nxt;
  logic          rise, fall, ce_q, wide, re, re_q;
  logic          quad, quad_nxt, is_rd, is_rd_nxt, qpi, qpi_nxt, dv, dv_nxt;
  logic          we, we_nxt;
  logic [23:0]   sr, sr_nxt, sr_in;
  logic [4:0]    cnt, cnt_nxt, cnt_inc, wait_n, wait_nxt;
  logic [AW-1:0] addr, addr_nxt, ra;
  logic [7:0]    pf, rbyte, byte_out, wdata, wdata_nxt;
  logic [3:0]    so, so_nxt;

  psram_sck_edge u_edge (.clk(clk), .rst(rst), .sck(bus.sck), .ce_n(bus.ce_n),
                         .rise(rise), .fall(fall));

  assign wide     = (state == CMD) ? qpi : quad;
  assign sr_in    = wide ? {sr[19:0], bus.sio_i} : {sr[22:0], bus.sio_i[0]};
  assign cnt_inc  = cnt + (wide ? 5'd4 : 5'd1);
  // read data is only guaranteed the cycle after mem_re, so it is parked in pf
  assign rbyte    = re_q ? bus.mem_rdata : pf;
  assign byte_out = (cnt == 5'd0) ? rbyte : sr[7:0];

  assign bus.mem_re    = re;
  assign bus.mem_addr  = re ? ra : addr;
  assign bus.mem_we    = we;
  assign bus.mem_wdata = wdata;
  assign bus.sio_o     = so;
  assign bus.qpi_mode  = qpi;
  assign bus.sio_oe    = (bus.ce_n || state != RDATA) ? 4'h0 :
                         quad ? (dv ? 4'hF : 4'h0) : 4'h2;

  always_comb begin
    state_nxt = state; sr_nxt = sr; cnt_nxt = cnt; wait_nxt = wait_n;
    quad_nxt = quad; is_rd_nxt = is_rd; qpi_nxt = qpi; dv_nxt = dv;
    so_nxt = so; we_nxt = 1'b0; wdata_nxt = wdata; re = 1'b0; ra = addr;
    addr_nxt = we ? addr + 1'b1 : addr;
    if (bus.ce_n) begin
      state_nxt = IDLE;
      dv_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: if (ce_q) begin
          state_nxt = CMD;
          cnt_nxt   = '0;
        end
        CMD: if (rise) begin
          sr_nxt = sr_in; cnt_nxt = cnt_inc;
          if (cnt_inc == 5'd8) begin
            cnt_nxt = '0; state_nxt = ADDR; quad_nxt = qpi; is_rd_nxt = 1'b1; wait_nxt = '0;
            case (sr_in[7:0])
              CMD_READ:   begin end
              CMD_FREAD:  wait_nxt = 5'(WAIT_FAST);
              CMD_QREAD:  begin quad_nxt = 1'b1; wait_nxt = 5'(WAIT_QUAD); end
              CMD_WRITE:  is_rd_nxt = 1'b0;
              CMD_QWRITE: begin quad_nxt = 1'b1; is_rd_nxt = 1'b0; end
              CMD_ENQPI:  begin qpi_nxt = 1'b1; state_nxt = IGNORE; end
              CMD_EXQPI:  begin qpi_nxt = 1'b0; state_nxt = IGNORE; end
              default:    state_nxt = IGNORE;
            endcase
          end
        end
        ADDR: if (rise) begin
          sr_nxt = sr_in; cnt_nxt = cnt_inc;
          if (cnt_inc == 5'd24) begin
            cnt_nxt  = '0;
            addr_nxt = sr_in[AW-1:0];
            if (!is_rd)              state_nxt = WDATA;
            else if (wait_n != 5'd0) state_nxt = WAIT;
            else begin
              state_nxt = RDATA; re = 1'b1; ra = sr_in[AW-1:0]; addr_nxt = ra + 1'b1;
            end
          end
        end
        WAIT: if (rise) begin
          cnt_nxt = cnt + 5'd1;
          if (cnt + 5'd1 == wait_n) begin
            cnt_nxt = '0; state_nxt = RDATA; re = 1'b1; addr_nxt = addr + 1'b1;
          end
        end
        RDATA: if (fall) begin
          dv_nxt      = 1'b1;
          cnt_nxt     = (cnt_inc == 5'd8) ? 5'd0 : cnt_inc;
          so_nxt      = quad ? byte_out[7:4] : {2'b00, byte_out[7], 1'b0};
          sr_nxt[7:0] = quad ? {byte_out[3:0], 4'h0} : {byte_out[6:0], 1'b0};
          // first unit of a byte out: prefetch the following byte
          if (cnt == 5'd0) begin
            re = 1'b1; addr_nxt = addr + 1'b1;
          end
        end
        WDATA: if (rise) begin
          sr_nxt = sr_in; cnt_nxt = cnt_inc;
          if (cnt_inc == 5'd8) begin
            cnt_nxt = '0; we_nxt = 1'b1; wdata_nxt = sr_in[7:0];
          end
        end
        default: begin end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE; ce_q <= 1'b0; sr <= '0; cnt <= '0; wait_n <= '0;
      quad <= 1'b0; is_rd <= 1'b0; qpi <= 1'b0; dv <= 1'b0; addr <= '0;
      re_q <= 1'b0; pf <= '0; so <= '0; we <= 1'b0; wdata <= '0;
    end else begin
      state <= state_nxt; ce_q <= bus.ce_n; sr <= sr_nxt; cnt <= cnt_nxt; wait_n <= wait_nxt;
      quad <= quad_nxt; is_rd <= is_rd_nxt; qpi <= qpi_nxt; dv <= dv_nxt; addr <= addr_nxt;
      re_q <= re; pf <= rbyte; so <= so_nxt; we <= we_nxt; wdata <= wdata_nxt;
    end
endmodule

// File: tb/tb_psram_qspi_responder.sv
// Bench for psram_qspi_responder: bus-functional master, SRAM model and write/read scoreboards.
module tb_psram_qspi_responder;
  import psram_pkg::*;
  localparam int AW = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psram_qspi_responder_if #(.AW(AW)) bus();
  psram_qspi_responder #(.AW(AW), .WAIT_FAST(8), .WAIT_QUAD(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  wr_t        wr_obs[$], wr_exp[$];
  logic [7:0] rd_exp[$];
  logic [7:0] mem [logic [AW-1:0]];
  int n_cmp = 0, n_bad = 0, both_hi = 0, strobes = 0, hp = 1;

  function automatic logic [7:0] mem_init(input logic [AW-1:0] a);
    if (a == 23'h10) return 8'hA5;
    if (a == 23'h11) return 8'h3C;
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk)
    if (bus.mem_re) bus.mem_rdata <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : mem_init(bus.mem_addr);

  always @(posedge clk)
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;

  always @(negedge clk) begin
    if (bus.mem_we) wr_obs.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.mem_we && bus.mem_re) both_hi++;
    if (bus.mem_we || bus.mem_re) strobes++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    bus.sio_i = d; q = bus.sio_o; oe = bus.sio_oe; bus.sck = 1'b1; tick(hp);
    bus.sck = 1'b0; tick(hp);
  endtask

  task automatic put_byte(input logic [7:0] b, input bit qd);
    logic [3:0] q, oe;
    if (qd) begin xfer(b[7:4], q, oe); xfer(b[3:0], q, oe); end
    else for (int i = 7; i >= 0; i--) xfer({3'b000, b[i]}, q, oe);
  endtask

  task automatic put_addr(input logic [23:0] a, input bit qd);
    put_byte(a[23:16], qd); put_byte(a[15:8], qd); put_byte(a[7:0], qd);
  endtask

  task automatic get_byte(input bit qd, output logic [7:0] b, output logic [3:0] oe_or, output logic [3:0] oe_and);
    logic [3:0] q, oe;
    b = '0; oe_or = '0; oe_and = 4'hF;
    for (int i = 0; i < (qd ? 2 : 8); i++) begin
      xfer(4'h0, q, oe);
      b = qd ? {b[3:0], q} : {b[6:0], q[1]};
      oe_or |= oe; oe_and &= oe;
    end
  endtask

  task automatic wait_phase(input int n, output logic [3:0] oe_or);
    logic [3:0] q, oe;
    oe_or = '0;
    for (int i = 0; i < n; i++) begin xfer(4'h0, q, oe); oe_or |= oe; end
  endtask

  task automatic begin_txn(); bus.ce_n = 1'b0; tick(1); endtask
  task automatic end_txn();   bus.ce_n = 1'b1; tick(3); endtask

  task automatic test_reset();
    tick(3);
    n_cmp++; if ({bus.sio_o, bus.sio_oe} !== 8'h00) begin n_bad++; $display("FAIL reset_sio: got %h want 00", {bus.sio_o, bus.sio_oe}); end
    n_cmp++; if ({bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata} !== '0) begin n_bad++; $display("FAIL reset_mem: got %h want 0", {bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata}); end
    n_cmp++; if (bus.qpi_mode !== 1'b0) begin n_bad++; $display("FAIL reset_qpi: got %b want 0", bus.qpi_mode); end
    rst = 1'b0; tick(2);
  endtask

  task automatic test_spi_write();
    wr_t w, e;
    hp = 1;
    begin_txn(); put_byte(CMD_WRITE, 0); put_addr(24'h000010, 0);
    wr_exp.push_back({23'h10, 8'hA5}); put_byte(8'hA5, 0);
    wr_exp.push_back({23'h11, 8'h3C}); put_byte(8'h3C, 0);
    end_txn();
    n_cmp++; if (wr_obs.size() != wr_exp.size()) begin n_bad++; $display("FAIL spi_wr_count: got %0d want %0d", wr_obs.size(), wr_exp.size()); end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      w = wr_obs.pop_front(); e = wr_exp.pop_front();
      n_cmp++; if (w !== e) begin n_bad++; $display("FAIL spi_wr: got %h/%h want %h/%h", w.a, w.d, e.a, e.d); end
    end
    wr_obs.delete(); wr_exp.delete();
  endtask

  task automatic test_fast_read();
    logic [7:0] b, e; logic [3:0] oor, oand;
    hp = 2;
    rd_exp.push_back(8'hA5); rd_exp.push_back(8'h3C);
    begin_txn(); put_byte(CMD_FREAD, 0); put_addr(24'h000010, 0);
    wait_phase(8, oor);
    n_cmp++; if (oor !== 4'h0) begin n_bad++; $display("FAIL fread_wait_oe: got %h want 0", oor); end
    repeat (2) begin
      get_byte(0, b, oor, oand); e = rd_exp.pop_front();
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL fread_data: got %h want %h", b, e); end
      n_cmp++; if (oor !== 4'h2 || oand !== 4'h2) begin n_bad++; $display("FAIL fread_oe: got %h/%h want 2", oor, oand); end
    end
    end_txn();
    hp = 1;
  endtask

  task automatic test_qspi_write_wrap();
    wr_t w, e;
    begin_txn(); put_byte(CMD_QWRITE, 0); put_addr(24'h7FFFFF, 1);
    wr_exp.push_back({23'h7FFFFF, 8'h11}); put_byte(8'h11, 1);
    wr_exp.push_back({23'h000000, 8'h22}); put_byte(8'h22, 1);
    end_txn();
    n_cmp++; if (wr_obs.size() != wr_exp.size()) begin n_bad++; $display("FAIL qwr_count: got %0d want %0d", wr_obs.size(), wr_exp.size()); end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      w = wr_obs.pop_front(); e = wr_exp.pop_front();
      n_cmp++; if (w !== e) begin n_bad++; $display("FAIL qwr: got %h/%h want %h/%h", w.a, w.d, e.a, e.d); end
    end
    wr_obs.delete(); wr_exp.delete();
  endtask

  task automatic test_qpi_read();
    logic [7:0] b, e; logic [3:0] oor, oand;
    begin_txn(); put_byte(CMD_ENQPI, 0);
    n_cmp++; if (bus.qpi_mode !== 1'b1) begin n_bad++; $display("FAIL qpi_enter: got %b want 1", bus.qpi_mode); end
    end_txn();
    rd_exp.push_back(8'hA5); rd_exp.push_back(8'h3C);
    begin_txn(); put_byte(CMD_QREAD, 1); put_addr(24'h000010, 1);
    wait_phase(6, oor);
    n_cmp++; if (oor !== 4'h0) begin n_bad++; $display("FAIL qread_wait_oe: got %h want 0", oor); end
    repeat (2) begin
      get_byte(1, b, oor, oand); e = rd_exp.pop_front();
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL qread_data: got %h want %h", b, e); end
      n_cmp++; if (oor !== 4'hF || oand !== 4'hF) begin n_bad++; $display("FAIL qread_oe: got %h/%h want f", oor, oand); end
    end
    end_txn();
    begin_txn(); put_byte(CMD_EXQPI, 1);
    n_cmp++; if (bus.qpi_mode !== 1'b0) begin n_bad++; $display("FAIL qpi_exit: got %b want 0", bus.qpi_mode); end
    end_txn();
  endtask

  task automatic test_abort();
    logic [3:0] q, oe; logic [7:0] b, e; logic [3:0] oor, oand;
    begin_txn(); put_byte(CMD_WRITE, 0); put_addr(24'h000010, 0);
    for (int i = 0; i < 4; i++) xfer(4'h1, q, oe);
    bus.ce_n = 1'b1; tick(1);
    n_cmp++; if (bus.sio_oe !== 4'h0) begin n_bad++; $display("FAIL abort_oe: got %h want 0", bus.sio_oe); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL abort_state: got %0d want %0d", dut.state, IDLE); end
    tick(3);
    n_cmp++; if (wr_obs.size() != 0) begin n_bad++; $display("FAIL abort_we: got %0d writes want 0", wr_obs.size()); end
    wr_obs.delete();
    rd_exp.push_back(8'hA5); rd_exp.push_back(8'h3C);
    begin_txn(); put_byte(CMD_READ, 0); put_addr(24'h000010, 0);
    repeat (2) begin
      get_byte(0, b, oor, oand); e = rd_exp.pop_front();
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL read03_data: got %h want %h", b, e); end
      n_cmp++; if (oand !== 4'h2) begin n_bad++; $display("FAIL read03_oe: got %h want 2", oand); end
    end
    end_txn();
  endtask

  task automatic test_rst_mid();
    logic [7:0] b, e; logic [3:0] oor, oand; int s0;
    rd_exp.push_back(8'hA5);
    begin_txn(); put_byte(CMD_READ, 0); put_addr(24'h000010, 0);
    get_byte(0, b, oor, oand); e = rd_exp.pop_front();
    n_cmp++; if (b !== e) begin n_bad++; $display("FAIL rst_pre_data: got %h want %h", b, e); end
    rst = 1'b1; #1;
    n_cmp++; if ({bus.sio_o, bus.sio_oe, bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata, bus.qpi_mode} !== '0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got %h want 0", {bus.sio_o, bus.sio_oe, bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata, bus.qpi_mode});
    end
    tick(2); rst = 1'b0; s0 = strobes;
    wait_phase(16, oor);
    n_cmp++; if (oor !== 4'h0 || strobes != s0) begin n_bad++; $display("FAIL rst_mid_quiet: got oe %h strobes %0d want 0 0", oor, strobes - s0); end
    end_txn();
  endtask

  task automatic test_ignore();
    logic [3:0] q, oe, oor; int s0;
    begin_txn(); put_byte(8'h9F, 0); s0 = strobes; oor = '0;
    for (int i = 0; i < 16; i++) begin xfer(4'($urandom_range(0, 15)), q, oe); oor |= oe; end
    n_cmp++; if (dut.state !== IGNORE) begin n_bad++; $display("FAIL ignore_state: got %0d want %0d", dut.state, IGNORE); end
    n_cmp++; if (strobes != s0 || oor !== 4'h0) begin n_bad++; $display("FAIL ignore_quiet: got strobes %0d oe %h want 0 0", strobes - s0, oor); end
    end_txn();
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL ignore_exit: got %0d want %0d", dut.state, IDLE); end
  endtask

  initial begin
    bus.sck = 1'b0; bus.ce_n = 1'b1; bus.sio_i = 4'h0; rst = 1'b1;
    test_reset();
    test_spi_write();
    test_fast_read();
    test_qspi_write_wrap();
    test_qpi_read();
    test_abort();
    test_rst_mid();
    test_ignore();
    n_cmp++; if (both_hi != 0) begin n_bad++; $display("FAIL re_we_overlap: got %0d want 0", both_hi); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule

// File: doc/psram_qspi_responder.md
# psram_qspi_responder

Synthesizable responder for the QSPI PSRAM bus: the device end of the SPI/QSPI/QPI link driven by the team's PSRAM controller. It decodes command, address, wait and data phases from `sck`/`ce_n`/SIO, then turns them into byte-wide accesses on a synchronous SRAM port. It serves as the PSRAM model in SoC simulation and as an FPGA stand-in for the external device. `sck` is treated as data and sampled in the `clk` domain; the master's `sck` must run at `clk`/2 or slower.

## Interface
- `AW`, 23: memory address width in bits; 2^AW bytes.
- `WAIT_FAST`, 8: `sck` cycles of wait for SPI fast read 0x0B.
- `WAIT_QUAD`, 6: `sck` cycles of wait for quad read 0xEB, in QSPI and QPI.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `sck` in 1: serial clock from the master.
- `ce_n` in 1: chip enable, active-low.
- `sio_i` in 4: SIO input. SPI uses `sio_i[0]` only.
- `sio_o` out 4: SIO output. SPI read data is on `sio_o[1]`.
- `sio_oe` out 4: per-line output enable.
- `mem_addr` out AW: byte address.
- `mem_re` out 1: read strobe. `mem_rdata` must be valid the cycle after `mem_re`.
- `mem_rdata` in 8: read data.
- `mem_we` out 1: one-cycle write strobe.
- `mem_wdata` out 8: write data.
- `qpi_mode` out 1: QPI mode flag, persistent across transactions.

## Operation
- Edge events, evaluated each `clk`, with `sck_q` the registered `sck`:
  - rise = `sck & ~sck_q`.
  - fall = `~sck & sck_q`.
  - Rise and fall events are ignored while `ce_n` = 1.
- Sampling and driving:
  - Inputs are sampled on rise.
  - `sio_o` is updated on fall.
  - Bits and nibbles are MSB-first.
- Command phase:
  - 8 rises of `sio_i[0]` when `qpi_mode` = 0.
  - 2 nibbles of `sio_i[3:0]` when `qpi_mode` = 1.
- Opcodes:
  - 0x03 read, SPI address, no wait.
  - 0x0B fast read, SPI address, `WAIT_FAST` wait cycles.
  - 0xEB quad read, quad address, `WAIT_QUAD` wait cycles, quad data.
  - 0x02 SPI write.
  - 0x38 quad write, quad address, quad data.
  - 0x35 sets `qpi_mode`.
  - 0xF5 clears `qpi_mode`.
- In QPI mode every address and data phase is quad.
- Any other opcode goes to IGNORE.
- Address phase: 24 bits, either 24 serial rises or 6 nibbles. `mem_addr` takes the low AW bits.
- States:
  - IDLE → CMD on the `ce_n` falling edge.
  - CMD → ADDR for read/write opcodes, → IGNORE for mode opcodes and unknown opcodes.
  - ADDR → WAIT if the wait count is nonzero, else → RDATA or WDATA.
  - WAIT → RDATA after the wait count of rises.
  - RDATA and WDATA run until `ce_n` rises.
  - IGNORE discards all activity until `ce_n` rises.
- Mode opcodes take effect on the 8th bit or 2nd nibble of the command.
- Read path:
  - `mem_re` pulses at the final rise of ADDR or WAIT.
  - `sio_o` loads the first unit from `mem_rdata` at the next fall.
  - When a byte's first unit is driven, `mem_re` is issued for address+1, so the byte is prefetched.
  - The address wraps at 2^AW.
- `sio_oe` values:
  - 4'b0010 in SPI RDATA.
  - 4'b1111 in quad RDATA, asserted from the first data fall.
  - 0 otherwise. This includes WAIT, which leaves a bus turnaround.
- Write path:
  - On each completed byte (8 rises or 2 nibbles), `mem_we` = 1 for one `clk` with `mem_wdata` = the byte.
  - The address then increments and wraps at 2^AW.
- Abort: `ce_n` = 1 at any time forces IDLE the next `clk`.
  - `sio_oe` = 0.
  - A partial write byte is discarded; no `mem_we`.
  - A partial command has no effect on `qpi_mode`.

## Timing
- Reset values:
  - State IDLE; `sck_q` = 0.
  - `sio_o` = 0, `sio_oe` = 0.
  - `mem_addr` = 0, `mem_re` = 0, `mem_we` = 0, `mem_wdata` = 0.
  - `qpi_mode` = 0.
- Reset mid-transaction returns the block to IDLE immediately. The rest of that transaction is ignored until `ce_n` rises and falls again.
- Minimum `sck` high and low phases: 1 `clk` each.
- `mem_re` to use of `mem_rdata`: exactly 1 `clk`. With `sck` at `clk`/2 this meets the first fall after ADDR when wait = 0.
- `mem_we` asserts on the `clk` following the completing rise.
- `mem_re` and `mem_we` are never both high.

## Structure
- Shared package `psram_pkg` holds:
  - Opcode constants: `CMD_READ` 0x03, `CMD_FREAD` 0x0B, `CMD_QREAD` 0xEB, `CMD_WRITE` 0x02, `CMD_QWRITE` 0x38, `CMD_ENQPI` 0x35, `CMD_EXQPI` 0xF5.
  - The state enum: IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE.
- Sub-module `psram_sck_edge` registers `sck` and produces the gated rise/fall events. Everything else sits in one FSM with one shift register and one bit counter.

## Test plan
- SPI 0x02 to address 0x000010, data A5 3C, then `ce_n` high → `mem_we` twice: (0x10, A5) then (0x11, 3C).
- SPI 0x0B at 0x000010 → `sio_oe` = 0 for 8 wait cycles, then `sio_o[1]` serializes A5 then 3C MSB-first, with `sio_oe` = 4'b0010.
- QSPI 0x38 at 0x7FFFFF (AW = 23), data 11 22 → writes (0x7FFFFF, 11) and (0x000000, 22), showing the address wrap.
- 0x35 then QPI 0xEB at 0x000010 → `qpi_mode` = 1; 6 wait cycles with `sio_oe` = 0; nibbles A,5,3,C with `sio_oe` = 4'b1111. Then 0xF5 → `qpi_mode` = 0.
- `ce_n` raised after 4 bits of a write data byte → no `mem_we`, state IDLE, `sio_oe` = 0. A following 0x03 read then returns the correct data.
- `rst` pulsed during the RDATA phase → all outputs at reset values on the same `clk`. Unknown opcode 0x9F → IGNORE, with no memory strobes until `ce_n` rises.
